sudoku_check_seq: RTL and testbench
===================================

Name: sudoku_check_seq

Overview:
Sequencer that validates the 9x9 sudoku grid held in the grid register file. On a start request it walks all 27 constraint units (9 rows, 9 columns, 9 3x3 boxes) through the grid's synchronous read port, one cell per cycle. Each value is checked against a per-unit "seen" bitmask. The first violation is reported with its unit type, unit index and cause. While the check runs, the block holds a lock output that stalls the grid loader.

Parameters:
STOP_ON_ERR, 1, 1 = stop issuing reads after the first error; 0 = finish all units (first error is still the one reported)
CHECK_BOXES, 1, 1 = check rows, columns and boxes (243 reads); 0 = rows and columns only (162 reads)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin check; sampled only in IDLE or DONE
abort  in  1  synchronous cancel; return to IDLE, outputs cleared
rd_en  out  1  grid read strobe
rd_row  out  4  grid row address, 0..8
rd_col  out  4  grid column address, 0..8
rd_data  in  4  grid cell value; valid the cycle after rd_en
grid_lock  out  1  high while busy; loader must not write the grid
busy  out  1  check in progress
done  out  1  check complete; holds until the next start or abort
err  out  1  at least one violation found; valid when done=1
err_type  out  2  violating unit: 0 row, 1 column, 2 box
err_idx  out  4  violating unit index, 0..8
err_code  out  2  cause: 1 duplicate, 2 value > 9

Behaviour:
- Reset (async): state IDLE; rd_en, busy, grid_lock, done, err = 0; err_type, err_idx, err_code, rd_row, rd_col = 0; mask cleared.
- Clock and reset: clk is the clock; rst_n is the asynchronous, active-low reset.
- States: IDLE -> ISSUE -> DRAIN -> DONE.
  - IDLE/DONE, start=1: go to ISSUE. Clear err, done, err_* and mask. Phase = ROW, unit u = 0, element k = 0.
  - ISSUE: rd_en = 1 every cycle. Address by phase:
    - ROW: (u, k)
    - COL: (k, u)
    - BOX: (3*(u/3) + k/3, 3*(u%3) + k%3)
  - Counter order: k increments 0..8 and wraps, incrementing u; u wraps 8 -> 0 and advances phase ROW -> COL -> BOX.
  - With CHECK_BOXES=0, COL wraps to end of issue.
  - After the last read is issued, or when an error is detected with STOP_ON_ERR=1: rd_en = 0, go to DRAIN.
  - DRAIN: one cycle for the final returned data, then go to DONE.
  - DONE: busy = 0, done = 1.
- Check stage (pipelined one cycle behind the issue stage):
  - Carries the issued phase, u and k alongside the returned data.
  - k == 0: mask treated as empty before this cell is tested.
  - Data 0: empty cell, skipped.
  - Data 1..9: if mask bit (data-1) is already set, duplicate; then set the bit.
  - Data 10..15: out-of-range error; mask unchanged.
- Error capture: the first error only sets err = 1 and latches err_type/err_idx/err_code from the check-stage tags. Later errors are ignored.
- With STOP_ON_ERR=1, a read already in flight when the error is flagged is discarded, not checked.
- Latency, error-free run with CHECK_BOXES=1:
  - start sampled at cycle 0.
  - rd_en high cycles 1..243, data checked cycles 2..244.
  - done = 1 and busy = 0 from cycle 245.
  - busy and grid_lock high cycles 1..244.
- Simultaneous events:
  - start while busy is ignored.
  - abort has priority over start and over all state transitions: next state IDLE, outputs at reset values.
  - rst_n low mid-run: immediate async clear; no done pulse.
- Width rules: box row/column computed with 4-bit arithmetic, no truncation (max 8). Mask is 9 bits.

Test Plan:
- Valid solved grid (row r, column c = ((3*(r%3) + r/3 + c) % 9) + 1), start -> 243 consecutive rd_en; done at cycle 245; err = 0.
- All-zero grid, start -> done at cycle 245; err = 0; grid_lock high cycles 1..244 only.
- Zero grid with (4,2)=5 and (4,7)=5 -> err=1, err_type=0, err_idx=4, err_code=1. With STOP_ON_ERR=1, rd_en stops after the read of (4,8).
- Zero grid with (2,3)=7 and (6,3)=7 -> err_type=1, err_idx=3, err_code=1.
- Zero grid with (0,0)=9 and (1,1)=9 -> err_type=2, err_idx=0, err_code=1. Same grid with CHECK_BOXES=0 -> err=0 after 162 reads, done at cycle 164.
- (8,8)=12 -> err_type=0, err_idx=8, err_code=2.
- start pulsed at cycle 50 -> ignored.
- abort at cycle 100 -> IDLE next cycle, busy = 0, done = 0.
- Restart after abort -> full 243-read run.

Source files
------------

// File: rtl/sudoku_check_seq.sv
// Sequencer that walks the 27 sudoku constraint units through a synchronous
// grid read port and reports the first duplicate or out-of-range value found.
module sudoku_check_seq #(
  parameter bit STOP_ON_ERR = 1'b1,
  parameter bit CHECK_BOXES = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       rd_en,
  output logic [3:0] rd_row,
  output logic [3:0] rd_col,
  input  logic [3:0] rd_data,
  output logic       grid_lock,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_type,
  output logic [3:0] err_idx,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {PH_ROW = 2'd0, PH_COL = 2'd1, PH_BOX = 2'd2} phase_t;

  state_t     r_state;
  phase_t     r_phase, r_chk_phase;
  logic [3:0] r_u, r_k, r_chk_u, r_chk_k;
  logic       r_chk_valid;
  logic [8:0] r_mask;

  phase_t     w_nxt_phase;
  logic [3:0] w_nxt_u, w_nxt_k;
  logic       w_last;
  logic [8:0] w_base, w_bit, w_mask_nxt;
  logic       w_zero, w_oor, w_dup, w_err_now;
  logic [1:0] w_code;

  function automatic logic [7:0] cell_addr(input phase_t ph, input logic [3:0] u,
                                           input logic [3:0] k);
    logic [3:0] row, col;
    case (ph)
      PH_ROW: begin row = u; col = k; end
      PH_COL: begin row = k; col = u; end
      default: begin
        row = 4'd3 * (u / 4'd3) + k / 4'd3;
        col = 4'd3 * (u % 4'd3) + k % 4'd3;
      end
    endcase
    return {row, col};
  endfunction

  // Issue-stage counters: k walks cells within a unit, u walks units, then phase.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_nxt_k     = r_k + 4'd1;
    w_nxt_u     = r_u;
    w_nxt_phase = r_phase;
    if (r_k == 4'd8) begin
      w_nxt_k = 4'd0;
      w_nxt_u = r_u + 4'd1;
      if (r_u == 4'd8) begin
        w_nxt_u     = 4'd0;
        w_nxt_phase = (r_phase == PH_ROW) ? PH_COL : PH_BOX;
      end
    end
  end

  assign w_last = (r_k == 4'd8) && (r_u == 4'd8) &&
                  ((r_phase == PH_BOX) || ((r_phase == PH_COL) && !CHECK_BOXES));

  // Check stage: the first cell of a unit starts from an empty mask.
  always_comb begin
    w_base     = (r_chk_k == 4'd0) ? 9'd0 : r_mask;
    w_zero     = (rd_data == 4'd0);
    w_oor      = (rd_data > 4'd9);
    w_bit      = 9'd1 << (rd_data - 4'd1);
    w_dup      = !w_zero && !w_oor && |(w_base & w_bit);
    w_mask_nxt = (w_zero || w_oor) ? w_base : (w_base | w_bit);
    w_err_now  = r_chk_valid && (w_dup || w_oor);
    w_code     = w_oor ? 2'd2 : 2'd1;
  end

  assign grid_lock = busy;

  // NOTE: sequential state uses non-blocking assignments only; abort clears the same set as reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;   r_phase <= PH_ROW;     r_u <= '0;       r_k <= '0;
      r_chk_phase <= PH_ROW; r_chk_u <= '0;       r_chk_k <= '0;   r_chk_valid <= 1'b0;
      r_mask <= '0;        rd_en <= 1'b0;         rd_row <= '0;    rd_col <= '0;
      busy <= 1'b0;        done <= 1'b0;          err <= 1'b0;
      err_type <= '0;      err_idx <= '0;         err_code <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;   r_phase <= PH_ROW;     r_u <= '0;       r_k <= '0;
      r_chk_phase <= PH_ROW; r_chk_u <= '0;       r_chk_k <= '0;   r_chk_valid <= 1'b0;
      r_mask <= '0;        rd_en <= 1'b0;         rd_row <= '0;    rd_col <= '0;
      busy <= 1'b0;        done <= 1'b0;          err <= 1'b0;
      err_type <= '0;      err_idx <= '0;         err_code <= '0;
    end else begin
      if (r_chk_valid) r_mask <= w_mask_nxt;
      if (w_err_now && !err) begin
        err      <= 1'b1;
        err_type <= r_chk_phase;
        err_idx  <= r_chk_u;
        err_code <= w_code;
      end
      // A read in flight behind a stopping error is dropped rather than checked.
      r_chk_valid <= rd_en && !(STOP_ON_ERR && w_err_now);
      r_chk_phase <= r_phase;
      r_chk_u     <= r_u;
      r_chk_k     <= r_k;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_ISSUE;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_type <= '0;
            err_idx  <= '0;
            err_code <= '0;
            r_mask   <= '0;
            r_phase  <= PH_ROW;
            r_u      <= '0;
            r_k      <= '0;
            rd_row   <= '0;
            rd_col   <= '0;
          end
        end
        S_ISSUE: begin
          if (w_last || (STOP_ON_ERR && w_err_now)) begin
            rd_en   <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_phase          <= w_nxt_phase;
            r_u              <= w_nxt_u;
            r_k              <= w_nxt_k;
            {rd_row, rd_col} <= cell_addr(w_nxt_phase, w_nxt_u, w_nxt_k);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_check_seq.sv
// Directed bench for sudoku_check_seq: default instance plus a rows/columns-only,
// run-to-completion instance, both reading a shared bench-side grid.
`timescale 1ns/1ps
module tb_sudoku_check_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic       rd_en_a, rd_en_b, lock_a, lock_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [3:0] row_a, col_a, row_b, col_b, data_a, data_b, idx_a, idx_b;
  logic [1:0] type_a, type_b, code_a, code_b;

  logic [3:0] grid [9][9];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int n_rd, first_rd, last_rd, last_row, last_col, lock_first, lock_last, lock_bad, done_cyc;
  } res_t;
  res_t r;

  task automatic check(input string tag, input bit ok, input longint obs, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always #5 clk = ~clk;

  sudoku_check_seq dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .rd_en(rd_en_a), .rd_row(row_a), .rd_col(col_a), .rd_data(data_a),
    .grid_lock(lock_a), .busy(busy_a), .done(done_a), .err(err_a),
    .err_type(type_a), .err_idx(idx_a), .err_code(code_a)
  );

  sudoku_check_seq #(.STOP_ON_ERR(1'b0), .CHECK_BOXES(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .rd_en(rd_en_b), .rd_row(row_b), .rd_col(col_b), .rd_data(data_b),
    .grid_lock(lock_b), .busy(busy_b), .done(done_b), .err(err_b),
    .err_type(type_b), .err_idx(idx_b), .err_code(code_b)
  );

  // Synchronous read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_a) data_a <= grid[row_a][col_a];
    if (rd_en_b) data_b <= grid[row_b][col_b];
  end

  task automatic clear_grid();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++) grid[i][j] = 4'd0;
  endtask

  task automatic solved_grid();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++) grid[i][j] = 4'(((3 * (i % 3) + i / 3 + j) % 9) + 1);
  endtask

  // Cycle 0 is the edge that samples start; cycle c is observed at the negedge after edge c.
  task automatic run(input bit which, input int pulse_at, input int abort_at, output res_t res);
    logic s_rd, s_lock, s_busy, s_done;
    logic [3:0] s_row, s_col;
    res = '{default: 0};
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (which) begin
        s_rd = rd_en_b; s_lock = lock_b; s_busy = busy_b; s_done = done_b; s_row = row_b; s_col = col_b;
      end else begin
        s_rd = rd_en_a; s_lock = lock_a; s_busy = busy_a; s_done = done_a; s_row = row_a; s_col = col_a;
      end
      if (s_rd) begin
        res.n_rd++;
        if (res.first_rd == 0) res.first_rd = c;
        res.last_rd = c; res.last_row = int'(s_row); res.last_col = int'(s_col);
      end
      if (s_lock) begin
        if (res.lock_first == 0) res.lock_first = c;
        res.lock_last = c;
      end
      if (s_lock !== s_busy) res.lock_bad++;
      if (s_done) begin res.done_cyc = c; break; end
      if (abort_at != 0 && c == abort_at + 1) break;
      if (c == pulse_at) begin if (which) start_b = 1'b1; else start_a = 1'b1; end
      if (c == abort_at) begin if (which) abort_b = 1'b1; else abort_a = 1'b1; end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    end
  endtask

  initial begin
    clear_grid();
    repeat (3) @(negedge clk);
    // Reset state, observed while rst_n is still low
    check("rst_rd_en", rd_en_a === 1'b0, rd_en_a, 0);
    check("rst_busy", busy_a === 1'b0, busy_a, 0);
    check("rst_lock", lock_a === 1'b0, lock_a, 0);
    check("rst_done", done_a === 1'b0, done_a, 0);
    check("rst_err", err_a === 1'b0, err_a, 0);
    check("rst_addr", {row_a, col_a} === 8'h00, {row_a, col_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Solved grid, with a stray start pulse at cycle 50 that must be ignored
    solved_grid();
    run(1'b0, 50, 0, r);
    check("ok_n_rd", r.n_rd === 243, r.n_rd, 243);
    check("ok_first_rd", r.first_rd === 1, r.first_rd, 1);
    check("ok_last_rd", r.last_rd === 243, r.last_rd, 243);
    check("ok_done_cyc", r.done_cyc === 245, r.done_cyc, 245);
    check("ok_busy_now", busy_a === 1'b0, busy_a, 0);
    check("ok_err", err_a === 1'b0, err_a, 0);
    repeat (3) @(negedge clk);
    check("ok_done_hold", done_a === 1'b1, done_a, 1);

    // All-zero grid: no errors, lock covers exactly cycles 1..244
    clear_grid();
    run(1'b0, 0, 0, r);
    check("zero_done_cyc", r.done_cyc === 245, r.done_cyc, 245);
    check("zero_err", err_a === 1'b0, err_a, 0);
    check("zero_lock_first", r.lock_first === 1, r.lock_first, 1);
    check("zero_lock_last", r.lock_last === 244, r.lock_last, 244);
    check("zero_lock_busy", r.lock_bad === 0, r.lock_bad, 0);

    // Row duplicate: stops after the in-flight read of (4,8)
    grid[4][2] = 4'd5; grid[4][7] = 4'd5;
    run(1'b0, 0, 0, r);
    check("row_err", err_a === 1'b1, err_a, 1);
    check("row_type", type_a === 2'd0, type_a, 0);
    check("row_idx", idx_a === 4'd4, idx_a, 4);
    check("row_code", code_a === 2'd1, code_a, 1);
    check("row_last_rd", r.last_rd === 45, r.last_rd, 45);
    check("row_last_addr", (r.last_row * 16 + r.last_col) === (4 * 16 + 8),
          r.last_row * 16 + r.last_col, 4 * 16 + 8);
    check("row_done_cyc", r.done_cyc === 47, r.done_cyc, 47);
    // Same grid on the run-to-completion, rows/columns-only instance
    run(1'b1, 0, 0, r);
    check("rowb_n_rd", r.n_rd === 162, r.n_rd, 162);
    check("rowb_done_cyc", r.done_cyc === 164, r.done_cyc, 164);
    check("rowb_err", err_b === 1'b1, err_b, 1);
    check("rowb_type", type_b === 2'd0, type_b, 0);
    check("rowb_idx", idx_b === 4'd4, idx_b, 4);
    check("rowb_code", code_b === 2'd1, code_b, 1);

    // Column duplicate
    clear_grid();
    grid[2][3] = 4'd7; grid[6][3] = 4'd7;
    run(1'b0, 0, 0, r);
    check("col_err", err_a === 1'b1, err_a, 1);
    check("col_type", type_a === 2'd1, type_a, 1);
    check("col_idx", idx_a === 4'd3, idx_a, 3);
    check("col_code", code_a === 2'd1, code_a, 1);

    // Box duplicate; invisible to the rows/columns-only instance
    clear_grid();
    grid[0][0] = 4'd9; grid[1][1] = 4'd9;
    run(1'b0, 0, 0, r);
    check("box_err", err_a === 1'b1, err_a, 1);
    check("box_type", type_a === 2'd2, type_a, 2);
    check("box_idx", idx_a === 4'd0, idx_a, 0);
    check("box_code", code_a === 2'd1, code_a, 1);
    run(1'b1, 0, 0, r);
    check("boxb_err", err_b === 1'b0, err_b, 0);
    check("boxb_n_rd", r.n_rd === 162, r.n_rd, 162);
    check("boxb_done_cyc", r.done_cyc === 164, r.done_cyc, 164);

    // Out-of-range value in the last cell of the last row
    clear_grid();
    grid[8][8] = 4'd12;
    run(1'b0, 0, 0, r);
    check("oor_err", err_a === 1'b1, err_a, 1);
    check("oor_type", type_a === 2'd0, type_a, 0);
    check("oor_idx", idx_a === 4'd8, idx_a, 8);
    check("oor_code", code_a === 2'd2, code_a, 2);

    // Abort at cycle 100, then a full restart
    solved_grid();
    run(1'b0, 0, 100, r);
    check("abort_n_rd", r.n_rd === 100, r.n_rd, 100);
    check("abort_busy", busy_a === 1'b0, busy_a, 0);
    check("abort_done", done_a === 1'b0, done_a, 0);
    check("abort_rd_en", rd_en_a === 1'b0, rd_en_a, 0);
    check("abort_lock", lock_a === 1'b0, lock_a, 0);
    repeat (3) @(negedge clk);
    check("abort_idle_done", done_a === 1'b0, done_a, 0);
    run(1'b0, 0, 0, r);
    check("restart_n_rd", r.n_rd === 243, r.n_rd, 243);
    check("restart_done_cyc", r.done_cyc === 245, r.done_cyc, 245);
    check("restart_err", err_a === 1'b0, err_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
